// File: rtl/cic_pkg.sv
// Shared types and width helpers for the CIC interpolator.
package cic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } cic_state_e;

  typedef enum logic {
    COMB  = 1'b0,
    INTEG = 1'b1
  } cic_mode_e;

  // Bit growth of an ORDER-stage interpolator is (ORDER-1)*RATE_SHIFT bits.
  function automatic int cic_int_width(int width, int order, int rate_shift);
    return width + (order - 1) * rate_shift;
  endfunction

  function automatic int cic_rate(int rate_shift);
    return 1 << rate_shift;
  endfunction

  function automatic int cic_out_shift(int order, int rate_shift);
    return (order - 1) * rate_shift;
  endfunction

endpackage

// File: rtl/cic_interp_if.sv
// Sample stream bundle for the CIC interpolator: one input stream, one output stream.
interface cic_interp_if #(
  parameter int WIDTH = 32
) ();
  // Both streams use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both 1; valid and data are held by the sender until then.
  logic signed [WIDTH-1:0] idata;
  logic                    ivalid;
  logic                    iready;
  logic signed [WIDTH-1:0] odata;
  logic                    ovalid;
  logic                    oready;

  modport slave (
    input  idata, ivalid, oready,
    output iready, odata, ovalid
  );

  modport master (
    output idata, ivalid, oready,
    input  iready, odata, ovalid
  );
endinterface

// File: rtl/cic_stage.sv
// One comb (differencer) or integrator (accumulator) register; out_o is the
// combinational result this stage passes to the next one in the chain.
module cic_stage
  import cic_pkg::*;
#(
  parameter int        W    = 34,
  parameter cic_mode_e MODE = COMB
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic signed [W-1:0] in_i,
  output logic signed [W-1:0] out_o
);

  logic signed [W-1:0] acc_q;
  logic signed [W-1:0] acc_d;

  if (MODE == COMB) begin : g_comb
    assign out_o = in_i - acc_q;
    assign acc_d = in_i;
  end else begin : g_integ
    assign out_o = acc_q + in_i;
    assign acc_d = out_o;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator by R = 2^RATE_SHIFT: ORDER combs at the input rate feeding
// ORDER integrators clocked once per output beat, unity DC gain.
module cic_interp
  import cic_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RATE_SHIFT = 2,
  parameter int ORDER      = 2
) (
  input  logic       clock,
  input  logic       reset,
  cic_interp_if.slave bus,
  output cic_state_e state_o
);

  localparam int W_INT = cic_int_width(WIDTH, ORDER, RATE_SHIFT);
  localparam int R     = cic_rate(RATE_SHIFT);
  localparam int SHIFT = cic_out_shift(ORDER, RATE_SHIFT);
  localparam int CW    = RATE_SHIFT + 1;

  cic_state_e              state_q;
  logic                    ovalid_q;
  logic [CW-1:0]           cnt_q;
  logic signed [WIDTH-1:0] odata_q;

  logic last_beat;
  logic accept;
  logic beat;
  logic load;

  assign last_beat  = (cnt_q == CW'(R));
  assign bus.iready = !ovalid_q | (bus.oready & last_beat);
  assign accept     = bus.ivalid & bus.iready;
  assign beat       = ovalid_q & bus.oready & !last_beat;
  assign load       = accept | beat;

  logic signed [W_INT-1:0] comb_c  [ORDER+1];
  logic signed [W_INT-1:0] integ_v [ORDER+1];

  assign comb_c[0]  = W_INT'(bus.idata);
  // The comb output enters the integrators only on the first beat of a burst.
  assign integ_v[0] = accept ? comb_c[ORDER] : '0;

  for (genvar k = 0; k < ORDER; k++) begin : g_stages
    cic_stage #(
      .W    (W_INT),
      .MODE (COMB)
    ) u_comb (
      .clk   (clock),
      .rst_n (reset),
      .en_i  (accept),
      .in_i  (comb_c[k]),
      .out_o (comb_c[k+1])
    );

    cic_stage #(
      .W    (W_INT),
      .MODE (INTEG)
    ) u_integ (
      .clk   (clock),
      .rst_n (reset),
      .en_i  (load),
      .in_i  (integ_v[k]),
      .out_o (integ_v[k+1])
    );
  end

  logic signed [W_INT-1:0] shifted;
  logic signed [WIDTH-1:0] odata_d;

  assign shifted = integ_v[ORDER] >>> SHIFT;
  assign odata_d = WIDTH'(shifted);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      ovalid_q <= 1'b0;
      cnt_q    <= '0;
      odata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= EMIT;
            ovalid_q <= 1'b1;
            cnt_q    <= CW'(1);
            odata_q  <= odata_d;
          end
        end
        EMIT: begin
          if (accept) begin
            cnt_q   <= CW'(1);
            odata_q <= odata_d;
          end else if (beat) begin
            cnt_q   <= cnt_q + CW'(1);
            odata_q <= odata_d;
          end else if (bus.oready && last_beat) begin
            state_q  <= IDLE;
            ovalid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          ovalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ovalid = ovalid_q;
  assign bus.odata  = odata_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cic_interp.sv
// Directed bench for cic_interp: 32-bit order-2 stream tests plus 8-bit wrap
// tests on order-2 and order-1 instances, all at R = 4.
module tb_cic_interp;
  import cic_pkg::*;

  localparam int R = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cic_interp_if #(.WIDTH(32)) b32 ();
  cic_interp_if #(.WIDTH(8))  b8a ();
  cic_interp_if #(.WIDTH(8))  b8b ();

  cic_state_e st32, st8a, st8b;

  cic_interp #(.WIDTH(32), .RATE_SHIFT(2), .ORDER(2)) u_dut32 (
    .clock (clk), .reset (rst_n), .bus (b32), .state_o (st32)
  );
  cic_interp #(.WIDTH(8), .RATE_SHIFT(2), .ORDER(2)) u_dut8a (
    .clock (clk), .reset (rst_n), .bus (b8a), .state_o (st8a)
  );
  cic_interp #(.WIDTH(8), .RATE_SHIFT(2), .ORDER(1)) u_dut8b (
    .clock (clk), .reset (rst_n), .bus (b8b), .state_o (st8b)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  int          in_q[$];
  logic [7:0]  exp_a_q[$];
  logic [7:0]  exp_b_q[$];
  int          xs[20];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    b32.ivalid = 1'b0; b32.idata = '0; b32.oready = 1'b1;
    b8a.ivalid = 1'b0; b8a.idata = '0; b8a.oready = 1'b1;
    b8b.ivalid = 1'b0; b8b.idata = '0; b8b.oready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives in_q with oready held high and checks every output beat against exp_q.
  task automatic run_stream(input string name, input bit nogap);
    int   beat     = 0;
    bit   started  = 0;
    bit   acc_prev = 0;
    int   budget   = 0;
    logic exp_ir;
    while ((in_q.size() > 0 || exp_q.size() > 0) && budget < 300) begin
      b32.ivalid = (in_q.size() > 0);
      b32.idata  = (in_q.size() > 0) ? in_q[0] : 0;
      b32.oready = 1'b1;
      #1;
      if (acc_prev) begin
        n_vec++;
        if (b32.ovalid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s latency: ovalid got %b exp 1 one cycle after accept", name, b32.ovalid);
        end
      end
      if (b32.ovalid === 1'b1) begin
        started = 1;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra beat: odata got %0d exp none", name, $signed(b32.odata));
        end else begin
          if (b32.odata !== exp_q[0]) begin
            n_fail++;
            $display("FAIL %s odata: got %0d exp %0d", name, $signed(b32.odata), $signed(exp_q[0]));
          end
          void'(exp_q.pop_front());
        end
        exp_ir = (beat == R - 1);
        n_vec++;
        if (b32.iready !== exp_ir) begin
          n_fail++;
          $display("FAIL %s iready at beat %0d: got %b exp %b", name, beat + 1, b32.iready, exp_ir);
        end
        beat = (beat + 1) % R;
      end else if (started && nogap) begin
        n_vec++;
        n_fail++;
        $display("FAIL %s gap: ovalid got %b exp 1 mid-stream", name, b32.ovalid);
      end
      acc_prev = b32.ivalid && b32.iready;
      if (acc_prev) void'(in_q.pop_front());
      @(negedge clk);
      budget++;
    end
    b32.ivalid = 1'b0;
    #1;
    n_vec++;
    if (exp_q.size() != 0 || in_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d beats outstanding exp 0", name, exp_q.size());
      exp_q.delete();
      in_q.delete();
    end else if (b32.ovalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s trailing: ovalid got %b exp 0 after burst", name, b32.ovalid);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (b32.ovalid !== 1'b0 || b32.odata !== 32'd0 || st32 !== IDLE) begin
      n_fail++;
      $display("FAIL reset32: ovalid=%b odata=%0d state=%0d exp 0/0/IDLE", b32.ovalid, b32.odata, st32);
    end
    n_vec++;
    if (b8a.ovalid !== 1'b0 || b8b.ovalid !== 1'b0 || b8a.odata !== 8'd0 || b8b.odata !== 8'd0) begin
      n_fail++;
      $display("FAIL reset8: ovalid=%b/%b odata=%0d/%0d exp 0", b8a.ovalid, b8b.ovalid, b8a.odata, b8b.odata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (b32.iready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset iready: got %b exp 1", b32.iready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    in_q  = '{0, 4};
    exp_q = '{0, 0, 0, 0, 1, 2, 3, 4};
    run_stream("basic", 1'b1);
  endtask

  task automatic test_ramp();
    do_reset();
    in_q  = '{0, 4, 8, 12, 12};
    exp_q = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 12, 12, 12, 12};
    run_stream("ramp", 1'b1);
  endtask

  task automatic test_negative();
    do_reset();
    in_q  = '{0, -8};
    exp_q = '{0, 0, 0, 0, -2, -4, -6, -8};
    run_stream("negative", 1'b1);
  endtask

  task automatic test_backpressure();
    do_reset();
    b32.ivalid = 1'b1; b32.idata = 32'd4; b32.oready = 1'b1;
    @(negedge clk);
    b32.ivalid = 1'b0;
    #1;
    n_vec++;
    if (b32.ovalid !== 1'b1 || b32.odata !== 32'd1) begin
      n_fail++;
      $display("FAIL bp beat1: ovalid=%b odata=%0d exp 1/1", b32.ovalid, b32.odata);
    end
    @(negedge clk);
    b32.oready = 1'b0; b32.ivalid = 1'b1; b32.idata = 32'd100;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (b32.ovalid !== 1'b1 || b32.odata !== 32'd2 || b32.iready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp hold %0d: ovalid=%b odata=%0d iready=%b exp 1/2/0", i, b32.ovalid, b32.odata, b32.iready);
      end
      @(negedge clk);
    end
    b32.oready = 1'b1; b32.ivalid = 1'b0;
    for (int b = 2; b <= 4; b++) begin
      #1;
      n_vec++;
      if (b32.ovalid !== 1'b1 || b32.odata !== 32'(b)) begin
        n_fail++;
        $display("FAIL bp resume: ovalid=%b odata=%0d exp 1/%0d", b32.ovalid, b32.odata, b);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (b32.ovalid !== 1'b0 || st32 !== IDLE) begin
        n_fail++;
        $display("FAIL bp ignored input: ovalid=%b state=%0d exp 0/IDLE", b32.ovalid, st32);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    b32.ivalid = 1'b1; b32.idata = 32'd4; b32.oready = 1'b1;
    @(negedge clk);
    b32.ivalid = 1'b0;
    #1;
    n_vec++;
    if (b32.odata !== 32'd1) begin
      n_fail++;
      $display("FAIL midrst beat1: odata got %0d exp 1", b32.odata);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (b32.odata !== 32'd2) begin
      n_fail++;
      $display("FAIL midrst beat2: odata got %0d exp 2", b32.odata);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (b32.ovalid !== 1'b0 || b32.odata !== 32'd0 || b32.iready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst cleared: ovalid=%b odata=%0d iready=%b exp 0/0/1", b32.ovalid, b32.odata, b32.iready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (b32.ovalid !== 1'b0 || b32.iready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst release: ovalid=%b iready=%b exp 0/1", b32.ovalid, b32.iready);
    end
    in_q  = '{4};
    exp_q = '{1, 2, 3, 4};
    run_stream("midrst_after", 1'b1);
  endtask

  // Order-2, R=4 interpolator as zero-stuffing followed by the triangular
  // kernel 1,2,3,4,3,2,1; the 10-bit internal value keeps bits [9:2].
  function automatic logic [7:0] model2(int n);
    int          y = 0;
    int          k;
    logic [31:0] yy;
    for (int m = 0; m < 20; m++) begin
      k = n - 4 * m;
      if (k >= 0 && k <= 6) y += ((k < 4) ? (k + 1) : (7 - k)) * xs[m];
    end
    yy = y;
    return yy[9:2];
  endfunction

  task automatic test_wrap();
    int idx    = 0;
    int budget = 0;
    logic [31:0] xv;
    do_reset();
    for (int m = 0; m < 20; m++) xs[m] = (m % 2 == 0) ? 127 : -128;
    for (int n = 0; n < 80; n++) begin
      exp_a_q.push_back(model2(n));
      xv = xs[n / 4];
      exp_b_q.push_back(xv[7:0]);
    end
    while ((idx < 20 || exp_a_q.size() > 0 || exp_b_q.size() > 0) && budget < 400) begin
      xv = (idx < 20) ? xs[idx] : 0;
      b8a.ivalid = (idx < 20); b8a.idata = xv[7:0]; b8a.oready = 1'b1;
      b8b.ivalid = (idx < 20); b8b.idata = xv[7:0]; b8b.oready = 1'b1;
      #1;
      if (b8a.ovalid === 1'b1) begin
        n_vec++;
        if (exp_a_q.size() == 0) begin
          n_fail++;
          $display("FAIL wrap_o2 extra beat: odata got %0d", $signed(b8a.odata));
        end else begin
          if (b8a.odata !== exp_a_q[0]) begin
            n_fail++;
            $display("FAIL wrap_o2 odata: got %0d exp %0d", $signed(b8a.odata), $signed(exp_a_q[0]));
          end
          void'(exp_a_q.pop_front());
        end
      end
      if (b8b.ovalid === 1'b1) begin
        n_vec++;
        if (exp_b_q.size() == 0) begin
          n_fail++;
          $display("FAIL wrap_o1 extra beat: odata got %0d", $signed(b8b.odata));
        end else begin
          if (b8b.odata !== exp_b_q[0]) begin
            n_fail++;
            $display("FAIL wrap_o1 odata: got %0d exp %0d", $signed(b8b.odata), $signed(exp_b_q[0]));
          end
          void'(exp_b_q.pop_front());
        end
      end
      n_vec++;
      if (b8a.iready !== b8b.iready) begin
        n_fail++;
        $display("FAIL wrap iready: order2 got %b, order1 got %b, exp equal", b8a.iready, b8b.iready);
      end
      if (b8a.ivalid && b8a.iready) idx++;
      @(negedge clk);
      budget++;
    end
    b8a.ivalid = 1'b0;
    b8b.ivalid = 1'b0;
    n_vec++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap timeout: %0d/%0d beats outstanding exp 0", exp_a_q.size(), exp_b_q.size());
      exp_a_q.delete();
      exp_b_q.delete();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_ramp();
    test_negative();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
